fsub_pipe: RTL and testbench

- 3-stage pipelined IEEE-754 single-precision subtractor: y = x1 - x2.
- Sits in the FPU execute path beside the combinational adder and serves FSUB instructions.
- valid/ready handshake on both sides; a destination tag travels with each operation.
- Numeric results are bit-identical to the adder applied to (x1, x2 with sign bit inverted), except where the special-value rules below differ.

---
 rtl/fsub_pipe.sv | 138 +++++++++++++
 tb/tb_fsub_pipe.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fsub_pipe.sv
// fsub_pipe: 3-stage pipelined IEEE-754 single-precision subtractor y = x1 - x2 with valid/ready and tag
module fsub_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction
  logic en, v1, v2;
  assign en = ~out_valid | out_ready;
  assign in_ready = en;
  logic        sa, sb, swap, sl, ss, nan1, nan2, inf1, inf2, spec;
  logic [7:0]  ea, eb, el, es, d;
  logic [23:0] ma, mb, ml, ms;
  logic [4:0]  shamt;
  logic [57:0] ext;
  logic [31:0] sv;
  always_comb begin
    sa = x1[31];
    sb = ~x2[31];
    ea = (x1[30:23] == 8'd0) ? 8'd1 : x1[30:23];
    eb = (x2[30:23] == 8'd0) ? 8'd1 : x2[30:23];
    ma = {|x1[30:23], x1[22:0]};
    mb = {|x2[30:23], x2[22:0]};
    swap = {eb, mb} > {ea, ma};
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    ml = swap ? mb : ma;
    ms = swap ? ma : mb;
    sl = swap ? sb : sa;
    ss = swap ? sa : sb;
    d = el - es;
    shamt = (d > 8'd31) ? 5'd31 : d[4:0];
    ext = {ms, 34'd0} >> shamt;
    nan1 = (&x1[30:23]) & (|x1[22:0]);
    nan2 = (&x2[30:23]) & (|x2[22:0]);
    inf1 = (&x1[30:23]) & ~(|x1[22:0]);
    inf2 = (&x2[30:23]) & ~(|x2[22:0]);
    spec = nan1 | nan2 | inf1 | inf2;
    sv = nan1 ? (x1 | 32'h0040_0000) :
         nan2 ? (x2 | 32'h0040_0000) :
         (inf1 & inf2 & (x1[31] == x2[31])) ? 32'hFFC0_0000 :
         inf1 ? x1 : {~x2[31], x2[30:0]};
  end
  logic             r1_sign, r1_sub, r1_zs, r1_st, r1_spec;
  logic [7:0]       r1_e;
  logic [23:0]      r1_ml;
  logic [25:0]      r1_al;
  logic [31:0]      r1_sv;
  logic [TAG_W-1:0] r1_tag;
  // sticky sits in the LSB column so a borrow from discarded bits propagates correctly
  logic [27:0] sum;
  logic [26:0] n, nl;
  logic [4:0]  lz;
  logic [7:0]  em1, sh;
  logic [8:0]  e0, e2;
  always_comb begin
    sum = r1_sub ? {1'b0, r1_ml, 3'b000} - {1'b0, r1_al, r1_st}
                 : {1'b0, r1_ml, 3'b000} + {1'b0, r1_al, r1_st};
    lz = lzc27(sum[26:0]);
    em1 = r1_e - 8'd1;
    sh = ({3'd0, lz} < em1) ? {3'd0, lz} : em1;
    nl = sum[26:0] << sh;
    e0 = {1'b0, r1_e} - {1'b0, sh};
    n = sum[27] ? {sum[27:2], sum[1] | sum[0]} : nl;
    e2 = sum[27] ? {1'b0, r1_e} + 9'd1 : (nl[26] ? e0 : 9'd0);
  end
  logic             r2_sign, r2_zs, r2_zero, r2_spec;
  logic [8:0]       r2_e;
  logic [26:0]      r2_m;
  logic [31:0]      r2_sv;
  logic [TAG_W-1:0] r2_tag;
  logic        up, big, ovf_d;
  logic [24:0] mr;
  logic [8:0]  ep;
  logic [22:0] frac;
  logic [31:0] y_d;
  always_comb begin
    up = r2_m[2] & (r2_m[1] | r2_m[0] | r2_m[3]);
    mr = {1'b0, r2_m[26:3]} + {24'd0, up};
    ep = (r2_e == 9'd0) ? {8'd0, mr[23]} : r2_e + {8'd0, mr[24]};
    frac = mr[24] ? mr[23:1] : mr[22:0];
    big = ep >= 9'd255;
    y_d = r2_spec ? r2_sv :
          r2_zero ? {r2_zs, 31'd0} :
          big ? {r2_sign, 8'hFF, 23'd0} : {r2_sign, ep[7:0], frac};
    ovf_d = v2 & ~r2_spec & ~r2_zero & big;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      y <= 32'd0;
      ovf <= 1'b0;
      out_tag <= '0;
    end else if (en) begin
      v1 <= in_valid;
      r1_sign <= sl;
      r1_sub <= sl ^ ss;
      r1_zs <= sa & sb;
      r1_e <= el;
      r1_ml <= ml;
      r1_al <= ext[57:32];
      r1_st <= |ext[31:0];
      r1_spec <= spec;
      r1_sv <= sv;
      r1_tag <= in_tag;
      v2 <= v1;
      r2_sign <= r1_sign;
      r2_zs <= r1_zs;
      r2_zero <= sum == 28'd0;
      r2_e <= e2;
      r2_m <= n;
      r2_spec <= r1_spec;
      r2_sv <= r1_sv;
      r2_tag <= r1_tag;
      out_valid <= v2;
      y <= y_d;
      ovf <= ovf_d;
      out_tag <= r2_tag;
    end
  end
endmodule

// File: tb/tb_fsub_pipe.sv
// tb_fsub_pipe: directed vectors for fsub_pipe covering latency, rounding, specials, backpressure and reset flush
module tb_fsub_pipe;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, ovf;
  logic [31:0] x1 = 32'd0, x2 = 32'd0, y;
  logic [4:0]  in_tag = 5'd0, out_tag;
  int total = 0, bad = 0;
  fsub_pipe #(.TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .ovf(ovf), .out_tag(out_tag)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run_vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ey, input logic eo, input logic [4:0] t);
    int n;
    logic found;
    @(posedge clk); #1;
    in_valid = 1'b1; x1 = a; x2 = b; in_tag = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    found = 1'b0;
    repeat (10) if (!found) begin
      @(negedge clk);
      n++;
      if (out_valid) found = 1'b1;
    end
    check({nm, "_lat"}, 32'(n), 32'd3);
    check({nm, "_y"}, y, ey);
    check({nm, "_ovf"}, 32'(ovf), 32'(eo));
    check({nm, "_tag"}, 32'(out_tag), 32'(t));
  endtask
  logic [31:0] bp_x2 [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
  logic [31:0] bp_y  [5] = '{32'h4000_0000, 32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000, 32'hC000_0000};
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int sent, exp_t, hold;
    logic seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    run_vec("basic",   32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd7);
    run_vec("cancel",  32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 5'd1);
    run_vec("nz_pz",   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 5'd2);
    run_vec("pz_nz",   32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 5'd3);
    run_vec("tie",     32'h4B80_0000, 32'hBF80_0000, 32'h4B80_0000, 1'b0, 5'd4);
    run_vec("sub3_1",  32'h0000_0003, 32'h0000_0001, 32'h0000_0002, 1'b0, 5'd5);
    run_vec("min_sub", 32'h0080_0000, 32'h0000_0001, 32'h007F_FFFF, 1'b0, 5'd6);
    run_vec("ovfl",    32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b1, 5'd8);
    run_vec("inf_inf", 32'h7F80_0000, 32'h7F80_0000, 32'hFFC0_0000, 1'b0, 5'd9);
    run_vec("snan",    32'h7FA0_0000, 32'h3F80_0000, 32'h7FE0_0000, 1'b0, 5'd10);
    run_vec("x2_inf",  32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 1'b0, 5'd11);
    sent = 0; exp_t = 1; hold = 0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid && !seen) begin
        seen = 1'b1;
        hold = 4;
      end
      out_ready = (hold == 0);
      in_valid = sent < 5;
      x1 = 32'h4040_0000;
      x2 = bp_x2[sent < 5 ? sent : 4];
      in_tag = 5'(sent + 1);
      @(negedge clk);
      if (hold > 0) begin
        check("bp_rdy", 32'(in_ready), 32'd0);
        check("bp_hold_tag", 32'(out_tag), 32'd1);
        check("bp_hold_y", y, bp_y[0]);
        hold--;
      end else if (seen && exp_t <= 5) begin
        check("bp_vld", 32'(out_valid), 32'd1);
        check("bp_order", 32'(out_tag), 32'(exp_t));
        check("bp_y", y, bp_y[exp_t-1]);
        exp_t++;
      end
      if (in_valid && in_ready) sent++;
    end
    check("bp_count", 32'(exp_t), 32'd6);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; x1 = 32'h4040_0000; x2 = 32'h3F80_0000; in_tag = 5'(20 + i);
      if (i == 2) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_vld", 32'(out_valid), 32'd0);
    check("flush_y", y, 32'd0);
    check("flush_ovf", 32'(ovf), 32'd0);
    check("flush_tag", 32'(out_tag), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("flush_none", 32'(out_valid), 32'd0);
    end
    run_vec("post_rst", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
